// File: rtl/irrig_pkg.sv
// ---------------------------------------------------------------------------
// irrig_pkg
// Shared definitions for the tank sensor front end:
//   - fill_state_t : fill-valve state machine encoding
//   - CODE_*       : the four legal debounced level codes {H,M,L}
//   - *_DEF        : default values for the front-end parameters
//   - code_valid() : true when a {H,M,L} code is one of the legal ones
// ---------------------------------------------------------------------------
package irrig_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,
        ST_IDLE   = 3'd1,
        ST_FILL   = 3'd2,
        ST_FULL   = 3'd3,
        ST_FAULT  = 3'd4
    } fill_state_t;

    // Probes are stacked, so a higher probe can only be wet if every lower
    // probe is wet too.
    localparam logic [2:0] CODE_EMPTY = 3'b000;
    localparam logic [2:0] CODE_LOW   = 3'b001;
    localparam logic [2:0] CODE_MID   = 3'b011;
    localparam logic [2:0] CODE_HIGH  = 3'b111;

    localparam int DEBOUNCE_CYC_DEF = 4;
    localparam int FILL_TIMEOUT_DEF = 1000;
    localparam int CLEAN_CYCLES_DEF = 8;

    function automatic logic code_valid(input logic [2:0] code);
        return (code == CODE_EMPTY) || (code == CODE_LOW) ||
               (code == CODE_MID)   || (code == CODE_HIGH);
    endfunction

endpackage

// File: rtl/probe_debounce.sv
// ---------------------------------------------------------------------------
// probe_debounce
// Two-flop synchronizer followed by a run-length debouncer for one tank probe.
// The output flips only after DEBOUNCE_CYC consecutive synchronized samples
// disagree with it; any agreeing sample restarts the run.
// Ports:
//   Clock  : system clock, rising edge
//   Reset  : asynchronous, active-high
//   raw    : asynchronous probe input
//   level  : debounced probe value
// ---------------------------------------------------------------------------
module probe_debounce
    import irrig_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic level
);

    localparam logic [2:0] RUN_LAST = 3'(DEBOUNCE_CYC - 1);

    logic       sync1_reg;
    logic       sync2_reg;
    logic       level_reg;
    logic [2:0] run_cnt_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            level_reg   <= 1'b0;
            run_cnt_reg <= 3'd0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg == level_reg) begin
                run_cnt_reg <= 3'd0;
            end else if (run_cnt_reg == RUN_LAST) begin
                // This sample completes the disagreeing run: accept it.
                level_reg   <= sync2_reg;
                run_cnt_reg <= 3'd0;
            end else begin
                run_cnt_reg <= run_cnt_reg + 3'd1;
            end
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/tank_sensor_front.sv
// ---------------------------------------------------------------------------
// tank_sensor_front
// Debounces the three tank probes, runs the fill-valve state machine and
// counts irrigation episodes to raise periodic cleaning requests.
// Ports:
//   Clock, Reset                       : clock / asynchronous active-high reset
//   Raw_H, Raw_M, Raw_L                : raw probes (1 = submerged)
//   Err_Ack                            : operator fault acknowledge
//   S_Aspersao, S_Gotejamento          : irrigation activity feedback
//   S_Limpeza                          : cleaning-done feedback
//   H, M, L                            : debounced probes
//   Ve                                 : fill-valve request
//   E                                  : error flag
//   Lp                                 : cleaning request
// ---------------------------------------------------------------------------
module tank_sensor_front
    import irrig_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF,
    parameter int CLEAN_CYCLES = CLEAN_CYCLES_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Raw_H,
    input  logic Raw_M,
    input  logic Raw_L,
    input  logic Err_Ack,
    input  logic S_Aspersao,
    input  logic S_Gotejamento,
    input  logic S_Limpeza,
    output logic H,
    output logic M,
    output logic L,
    output logic Ve,
    output logic E,
    output logic Lp
);

    // Settling covers the synchronizer plus one full debounce run.
    localparam logic [3:0]  SETTLE_LAST  = 4'(DEBOUNCE_CYC + 2);
    localparam logic [15:0] TIMEOUT_LAST = 16'(FILL_TIMEOUT - 1);
    localparam logic [3:0]  CLEAN_TARGET = 4'(CLEAN_CYCLES);

    // -----------------------------------------------------------------------
    // Probe conditioning; bit order is {H, M, L}
    // -----------------------------------------------------------------------
    logic [2:0] raw_vec;
    logic [2:0] level_vec;

    assign raw_vec = {Raw_H, Raw_M, Raw_L};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_probe
            probe_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_probe (
                .Clock(Clock),
                .Reset(Reset),
                .raw  (raw_vec[gi]),
                .level(level_vec[gi])
            );
        end
    endgenerate

    assign {H, M, L} = level_vec;

    logic code_ok;
    assign code_ok = code_valid(level_vec);

    // -----------------------------------------------------------------------
    // Fill state machine
    // -----------------------------------------------------------------------
    fill_state_t state_reg;
    logic [3:0]  settle_cnt_reg;
    logic [15:0] fill_timer_reg;
    logic        ve_reg;
    logic        fault_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg      <= ST_SETTLE;
            settle_cnt_reg <= 4'd0;
            fill_timer_reg <= 16'd0;
            ve_reg         <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            // Outputs follow the state one cycle later.
            ve_reg    <= (state_reg == ST_FILL);
            fault_reg <= (state_reg == ST_FAULT);

            case (state_reg)
                ST_SETTLE: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 4'd1;
                    end
                end
                ST_IDLE: begin
                    if (!code_ok) begin
                        state_reg <= ST_FAULT;
                    end else if (!level_vec[0]) begin
                        state_reg      <= ST_FILL;
                        fill_timer_reg <= 16'd0;
                    end
                end
                ST_FILL: begin
                    // An invalid code is checked first so it beats H.
                    if (!code_ok) begin
                        state_reg <= ST_FAULT;
                    end else if (level_vec[2]) begin
                        state_reg <= ST_FULL;
                    end else if (fill_timer_reg == TIMEOUT_LAST) begin
                        state_reg <= ST_FAULT;
                    end else begin
                        fill_timer_reg <= fill_timer_reg + 16'd1;
                    end
                end
                ST_FULL: begin
                    // Leaving on M only gives hysteresis: refill waits for L.
                    if (!code_ok) begin
                        state_reg <= ST_FAULT;
                    end else if (!level_vec[1]) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (Err_Ack && code_ok) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_SETTLE;
                end
            endcase
        end
    end

    assign Ve = ve_reg;
    // A bad probe code is flagged immediately, independent of the state.
    assign E  = fault_reg | ~code_ok;

    // -----------------------------------------------------------------------
    // Irrigation episode counter and cleaning request
    // -----------------------------------------------------------------------
    logic       asp_prev_reg;
    logic       got_prev_reg;
    logic [3:0] episode_cnt_reg;
    logic       lp_reg;
    logic       episode_end;

    // Either falling edge (or both at once) is a single episode.
    assign episode_end = (asp_prev_reg & ~S_Aspersao) |
                         (got_prev_reg & ~S_Gotejamento);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            asp_prev_reg    <= 1'b0;
            got_prev_reg    <= 1'b0;
            episode_cnt_reg <= 4'd0;
            lp_reg          <= 1'b0;
        end else begin
            asp_prev_reg <= S_Aspersao;
            got_prev_reg <= S_Gotejamento;
            if (S_Limpeza) begin
                // Cleaning done beats a coincident episode, which is dropped.
                episode_cnt_reg <= 4'd0;
                lp_reg          <= 1'b0;
            end else begin
                if (episode_end && (episode_cnt_reg != CLEAN_TARGET)) begin
                    episode_cnt_reg <= episode_cnt_reg + 4'd1;
                end
                if (episode_cnt_reg == CLEAN_TARGET) begin
                    lp_reg <= 1'b1;
                end
            end
        end
    end

    assign Lp = lp_reg;

endmodule

// File: tb/tb_tank_sensor_front.sv
// ---------------------------------------------------------------------------
// tb_tank_sensor_front
// Directed scenarios followed by randomized stimulus; every cycle the DUT
// outputs are compared with a behavioural model of the tank front end.
// ---------------------------------------------------------------------------
module tb_tank_sensor_front;

    localparam int D = 4;
    localparam int T = 20;
    localparam int C = 3;

    localparam int S_SETTLE = 0;
    localparam int S_IDLE   = 1;
    localparam int S_FILL   = 2;
    localparam int S_FULL   = 3;
    localparam int S_FAULT  = 4;

    logic Clock = 1'b0;
    logic Reset;
    logic Raw_H, Raw_M, Raw_L;
    logic Err_Ack;
    logic S_Aspersao, S_Gotejamento, S_Limpeza;
    logic H, M, L, Ve, E, Lp;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    tank_sensor_front #(
        .DEBOUNCE_CYC(D),
        .FILL_TIMEOUT(T),
        .CLEAN_CYCLES(C)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Raw_H        (Raw_H),
        .Raw_M        (Raw_M),
        .Raw_L        (Raw_L),
        .Err_Ack      (Err_Ack),
        .S_Aspersao   (S_Aspersao),
        .S_Gotejamento(S_Gotejamento),
        .S_Limpeza    (S_Limpeza),
        .H            (H),
        .M            (M),
        .L            (L),
        .Ve           (Ve),
        .E            (E),
        .Lp           (Lp)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    bit [2:0] m_s1, m_s2, m_lev;     // {H,M,L}
    bit       hist [3][8];           // newest debouncer sample at index 0
    int       m_state, m_cyc;
    bit       m_ve, m_fault;
    bit       m_pa, m_pg, m_lp;
    int       m_cnt;

    function automatic bit code_ok(input bit [2:0] c);
        return (c == 3'd0) || (c == 3'd1) || (c == 3'd3) || (c == 3'd7);
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lev = 0;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 8; i++) hist[p][i] = 1'b0;
        m_state = S_SETTLE; m_cyc = 0;
        m_ve = 0; m_fault = 0;
        m_pa = 0; m_pg = 0; m_cnt = 0; m_lp = 0;
    endtask

    task automatic model_step();
        bit [2:0] lev;
        bit ok, fall, differs, new_lp;
        int nst;
        lev = m_lev;
        ok  = code_ok(lev);
        nst = m_state;
        case (m_state)
            S_SETTLE: if (m_cyc + 1 == D + 3) nst = S_IDLE;
            S_IDLE:   if (!ok) nst = S_FAULT; else if (!lev[0]) nst = S_FILL;
            S_FILL:   if (!ok) nst = S_FAULT; else if (lev[2]) nst = S_FULL;
                      else if (m_cyc + 1 >= T) nst = S_FAULT;
            S_FULL:   if (!ok) nst = S_FAULT; else if (!lev[1]) nst = S_IDLE;
            S_FAULT:  if (Err_Ack && ok) nst = S_IDLE;
            default:  nst = m_state;
        endcase
        m_ve    = (m_state == S_FILL);
        m_fault = (m_state == S_FAULT);
        m_cyc   = (nst != m_state) ? 0 : m_cyc + 1;
        m_state = nst;

        // Debounce: flip when the last D synchronized samples all disagree.
        for (int p = 0; p < 3; p++) begin
            for (int i = 7; i > 0; i--) hist[p][i] = hist[p][i-1];
            hist[p][0] = m_s2[p];
            differs = 1'b1;
            for (int i = 0; i < D; i++)
                if (hist[p][i] == m_lev[p]) differs = 1'b0;
            if (differs) m_lev[p] = ~m_lev[p];
        end
        m_s2 = m_s1;
        m_s1 = {Raw_H, Raw_M, Raw_L};

        fall = (m_pa && !S_Aspersao) || (m_pg && !S_Gotejamento);
        if (S_Limpeza) begin
            new_lp = 1'b0;
            m_cnt  = 0;
        end else begin
            new_lp = m_lp || (m_cnt == C);
            if (fall && m_cnt < C) m_cnt++;
        end
        m_lp = new_lp;
        m_pa = S_Aspersao;
        m_pg = S_Gotejamento;
    endtask

    always @(posedge Clock) begin
        if (Reset) model_reset();
        else       model_step();
    end

    always @(negedge Clock) begin
        if (!Reset && cmp_en) begin
            chk("H",  32'(H),  32'(m_lev[2]));
            chk("M",  32'(M),  32'(m_lev[1]));
            chk("L",  32'(L),  32'(m_lev[0]));
            chk("Ve", 32'(Ve), 32'(m_ve));
            chk("E",  32'(E),  32'(m_fault || !code_ok(m_lev)));
            chk("Lp", 32'(Lp), 32'(m_lp));
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic set_raw(input bit [2:0] c);
        {Raw_H, Raw_M, Raw_L} = c;
    endtask

    task automatic ack_pulse();
        Err_Ack = 1'b1;
        tick();
        Err_Ack = 1'b0;
    endtask

    // Falling edge of the selected feedback lines, seen at the second edge.
    task automatic episode(input bit a, input bit g);
        S_Aspersao = a; S_Gotejamento = g;
        tick();
        S_Aspersao = 1'b0; S_Gotejamento = 1'b0;
        tick();
    endtask

    task automatic wait_ve(input string tag);
        int n = 0;
        while (Ve !== 1'b1 && n < 40) begin tick(); n++; end
        chk(tag, 32'(Ve), 32'd1);
    endtask

    task automatic pulse_reset();
        #2 Reset = 1'b1;
        #1;
        chk("rst_async_Ve", 32'(Ve), 32'd0);
        chk("rst_async_E",  32'(E),  32'd0);
        chk("rst_async_Lp", 32'(Lp), 32'd0);
        tick();
        tick();
        Reset = 1'b0;
    endtask

    logic [2:0] valid_codes [4];
    logic [2:0] bad_codes   [4];

    initial begin
        int fill_start, n, hold;
        valid_codes = '{3'b000, 3'b001, 3'b011, 3'b111};
        bad_codes   = '{3'b010, 3'b100, 3'b101, 3'b110};

        Reset = 1'b1;
        set_raw(3'b000);
        Err_Ack = 0; S_Aspersao = 0; S_Gotejamento = 0; S_Limpeza = 0;
        ticks(3);
        chk("rst_H", 32'(H), 0);  chk("rst_M", 32'(M), 0);  chk("rst_L", 32'(L), 0);
        chk("rst_Ve", 32'(Ve), 0); chk("rst_E", 32'(E), 0); chk("rst_Lp", 32'(Lp), 0);
        Reset = 1'b0;
        cmp_en = 1'b1;
        $display("reset released at %0t", $time);

        // Settling, then automatic fill of the empty tank.
        for (int i = 0; i < D + 4; i++) begin
            tick();
            chk("settle_Ve", 32'(Ve), 0);
        end
        tick();
        chk("fill_Ve", 32'(Ve), 1);
        fill_start = cyc;
        $display("settle done, fill started at cycle %0d", cyc);

        // Short glitch on L must never appear.
        Raw_L = 1'b1;
        ticks(3);
        Raw_L = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("glitch_L", 32'(L), 0);
        end
        // A four-sample pulse appears exactly D+2 edges after it starts.
        Raw_L = 1'b1;
        ticks(4);
        Raw_L = 1'b0;
        tick();
        chk("pulse_L_early", 32'(L), 0);
        tick();
        chk("pulse_L", 32'(L), 1);
        $display("debounce glitch/pulse done at cycle %0d", cyc);

        // Fill timeout with H never rising.
        n = 0;
        while (E !== 1'b1 && n < 60) begin tick(); n++; end
        chk("timeout_cycles", 32'(cyc - fill_start), 32'(T));
        chk("timeout_Ve", 32'(Ve), 0);
        set_raw(3'b011);
        ticks(12);
        chk("fault_held_E", 32'(E), 1);
        ack_pulse();
        tick();
        chk("ack_E", 32'(E), 0);
        chk("ack_Ve", 32'(Ve), 0);
        $display("timeout fault and acknowledge done at cycle %0d", cyc);

        // Normal fill L, M, H then hysteresis.
        set_raw(3'b000);
        wait_ve("refill_Ve");
        Raw_L = 1'b1; ticks(3);
        Raw_M = 1'b1; ticks(3);
        Raw_H = 1'b1;
        n = 0;
        while (H !== 1'b1 && n < 20) begin tick(); n++; end
        chk("full_H", 32'(H), 1);
        ticks(2);
        chk("full_Ve", 32'(Ve), 0);
        Raw_H = 1'b0; ticks(10);
        chk("drop_H_Ve", 32'(Ve), 0);
        Raw_M = 1'b0; ticks(10);
        chk("drop_M_Ve", 32'(Ve), 0);
        Raw_L = 1'b0;
        wait_ve("drop_L_Ve");
        $display("fill and hysteresis done at cycle %0d", cyc);

        // Invalid code while FULL.
        Raw_L = 1'b1; ticks(3);
        Raw_M = 1'b1; ticks(3);
        Raw_H = 1'b1; ticks(10);
        chk("full2_Ve", 32'(Ve), 0);
        chk("full2_E", 32'(E), 0);
        Raw_M = 1'b0; ticks(10);
        chk("bad_code_E", 32'(E), 1);
        ack_pulse();
        ticks(3);
        Raw_M = 1'b1; ticks(10);
        chk("ack_ignored_E", 32'(E), 1);
        ack_pulse();
        tick();
        chk("ack_valid_E", 32'(E), 0);
        chk("ack_valid_Ve", 32'(Ve), 0);
        $display("invalid code fault done at cycle %0d", cyc);

        // Episodes and cleaning.
        episode(1, 0);
        episode(1, 1);
        episode(1, 0);
        chk("lp_before", 32'(Lp), 0);
        tick();
        chk("lp_set", 32'(Lp), 1);
        ticks(4);
        chk("lp_hold", 32'(Lp), 1);
        S_Aspersao = 1'b1;
        tick();
        S_Aspersao = 1'b0; S_Limpeza = 1'b1;
        tick();
        S_Limpeza = 1'b0;
        chk("lp_clear", 32'(Lp), 0);
        episode(1, 0);
        episode(0, 1);
        ticks(2);
        chk("lp_cnt_cleared", 32'(Lp), 0);
        episode(1, 0);
        ticks(2);
        chk("lp_again", 32'(Lp), 1);
        S_Limpeza = 1'b1; tick(); S_Limpeza = 1'b0;
        chk("lp_clear2", 32'(Lp), 0);
        $display("cleaning counter done at cycle %0d", cyc);

        // Reset while filling and while faulted.
        set_raw(3'b000);
        wait_ve("pre_reset_fill");
        pulse_reset();
        n = 0;
        while (E !== 1'b1 && n < 80) begin tick(); n++; end
        chk("pre_reset_fault", 32'(E), 1);
        pulse_reset();
        tick();
        chk("post_reset_E", 32'(E), 0);
        $display("reset during fill/fault done at cycle %0d", cyc);

        // Randomized traffic against the model.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 9) == 0) set_raw(bad_codes[$urandom_range(0, 3)]);
                else                           set_raw(valid_codes[$urandom_range(0, 3)]);
                hold = $urandom_range(1, 30);
            end
            hold--;
            Err_Ack = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) S_Aspersao    = ~S_Aspersao;
            if ($urandom_range(0, 5) == 0) S_Gotejamento = ~S_Gotejamento;
            S_Limpeza = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            tick();
        end
        $display("random phase done at cycle %0d", cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
